// File: rtl/save_msx_config.sv
// save_msx_config: walks the MSX slot-configuration table and rewrites each
// active entry's 16-byte "MSX" header in place in DDR3, at store_address - 0x10.
// Payload bytes that follow the header are never touched.

package MSX;
    typedef enum logic [7:0] {
        CONFIG_NONE = 8'h00,
        CONFIG_ROM  = 8'h02,
        CONFIG_FDC  = 8'h03,
        CONFIG_RAM  = 8'h05
    } config_typ_t;

    typedef struct packed {
        logic [1:0]  slot;
        logic [1:0]  sub_slot;
        logic [1:0]  start_block;
        config_typ_t typ;
        logic [3:0]  block_id;
        logic [7:0]  block_count;
        logic [27:0] store_address;
    } msx_config_t;
endpackage

module save_msx_config #(
    parameter int MAX_CONFIG = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               save_start,
    input  logic [1:0]         msx_type,
    input  MSX::msx_config_t   msx_config [MAX_CONFIG],
    output logic               ddr3_request,
    input  logic               ddr3_ready,
    output logic [27:0]        ddr3_addr,
    output logic [7:0]         ddr3_din,
    output logic               ddr3_wr,
    output logic               save_busy,
    output logic               save_done,
    input  logic               save_ack,
    output logic [4:0]         written_count,
    output logic [4:0]         skipped_bad
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        CHECK = 3'd2,
        WRITE = 3'd3,
        NEXT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t           state_r;
    logic [3:0]       idx_r;
    logic [3:0]       byte_r;
    logic [27:0]      base_r;
    MSX::msx_config_t entry_r;
    logic [1:0]       type_r;

    // Header byte b of the block described by entry e on machine type mt.
    function automatic logic [7:0] header_byte(
        input logic [3:0]       b,
        input MSX::msx_config_t e,
        input logic [1:0]       mt
    );
        logic [7:0] v;
        case (b)
            4'd0:    v = 8'h4D;
            4'd1:    v = 8'h53;
            4'd2:    v = 8'h58;
            4'd3:    v = {6'b0, mt};
            4'd4:    v = {6'b0, e.slot};
            4'd5:    v = {6'b0, e.sub_slot};
            4'd6:    v = {6'b0, e.start_block};
            4'd7:    v = e.typ;
            4'd8:    v = {4'b0, e.block_id};
            4'd9:    v = e.block_count;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // Saturating +1 for the 5-bit pass counters (ceiling 16).
    function automatic logic [4:0] sat_inc(input logic [4:0] c);
        return (c == 5'd16) ? c : c + 5'd1;
    endfunction

    // Save sequencer: table walk, DDR3 byte handshake and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            idx_r         <= 4'd0;
            byte_r        <= 4'd0;
            base_r        <= 28'd0;
            entry_r       <= '0;
            type_r        <= 2'd0;
            ddr3_request  <= 1'b0;
            ddr3_addr     <= 28'd0;
            ddr3_din      <= 8'd0;
            ddr3_wr       <= 1'b0;
            save_busy     <= 1'b0;
            save_done     <= 1'b0;
            written_count <= 5'd0;
            skipped_bad   <= 5'd0;
        end else begin
            // Acknowledge clears the flag; a DONE in the same cycle overrides below.
            if (save_ack) begin
                save_done <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (save_start) begin
                        idx_r         <= 4'd0;
                        written_count <= 5'd0;
                        skipped_bad   <= 5'd0;
                        ddr3_request  <= 1'b1;
                        save_busy     <= 1'b1;
                        state_r       <= GRANT;
                    end
                end
                GRANT: begin
                    if (ddr3_ready) begin
                        state_r <= CHECK;
                    end
                end
                CHECK: begin
                    // Fields are captured here so table edits mid-header have no effect.
                    entry_r <= msx_config[idx_r];
                    type_r  <= msx_type;
                    base_r  <= msx_config[idx_r].store_address - 28'h10;
                    byte_r  <= 4'd0;
                    if (msx_config[idx_r].typ == MSX::CONFIG_NONE) begin
                        state_r <= NEXT;
                    end else if (msx_config[idx_r].store_address < 28'h10) begin
                        skipped_bad <= sat_inc(skipped_bad);
                        state_r     <= NEXT;
                    end else begin
                        state_r <= WRITE;
                    end
                end
                WRITE: begin
                    if (!ddr3_wr) begin
                        if (ddr3_ready) begin
                            ddr3_wr   <= 1'b1;
                            ddr3_addr <= base_r + {24'd0, byte_r};
                            ddr3_din  <= header_byte(byte_r, entry_r, type_r);
                        end
                    end else if (ddr3_ready) begin
                        // Byte accepted: drop the strobe for one cycle before the next.
                        ddr3_wr <= 1'b0;
                        byte_r  <= byte_r + 4'd1;
                        if (byte_r == 4'd15) begin
                            written_count <= sat_inc(written_count);
                            state_r       <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    if (idx_r == 4'(MAX_CONFIG - 1)) begin
                        state_r <= DONE;
                    end else begin
                        idx_r   <= idx_r + 4'd1;
                        state_r <= GRANT;
                    end
                end
                DONE: begin
                    save_done    <= 1'b1;
                    ddr3_request <= 1'b0;
                    save_busy    <= 1'b0;
                    state_r      <= IDLE;
                end
                default: begin
                    ddr3_wr      <= 1'b0;
                    ddr3_request <= 1'b0;
                    save_busy    <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_save_msx_config.sv
// Directed self-checking bench for save_msx_config.

module tb_save_msx_config;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             save_start = 1'b0;
    logic [1:0]       msx_type = 2'd1;
    MSX::msx_config_t cfg [16];
    logic             ddr3_request;
    logic             ddr3_ready = 1'b1;
    logic [27:0]      ddr3_addr;
    logic [7:0]       ddr3_din;
    logic             ddr3_wr;
    logic             save_busy;
    logic             save_done;
    logic             save_ack = 1'b0;
    logic [4:0]       written_count;
    logic [4:0]       skipped_bad;

    int checks = 0;
    int failures = 0;
    int req_err = 0;

    logic [27:0] wa_q [$];
    logic [7:0]  wd_q [$];

    save_msx_config #(.MAX_CONFIG(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .save_start   (save_start),
        .msx_type     (msx_type),
        .msx_config   (cfg),
        .ddr3_request (ddr3_request),
        .ddr3_ready   (ddr3_ready),
        .ddr3_addr    (ddr3_addr),
        .ddr3_din     (ddr3_din),
        .ddr3_wr      (ddr3_wr),
        .save_busy    (save_busy),
        .save_done    (save_done),
        .save_ack     (save_ack),
        .written_count(written_count),
        .skipped_bad  (skipped_bad)
    );

    always #5 clk = ~clk;

    // Record every accepted byte.
    always @(posedge clk) begin
        if (ddr3_wr && ddr3_ready) begin
            wa_q.push_back(ddr3_addr);
            wd_q.push_back(ddr3_din);
        end
    end

    // Bus request must track busy (high in every non-IDLE state).
    always @(negedge clk) begin
        if (reset_n && (ddr3_request !== save_busy)) req_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < 16; i++) cfg[i] = '0;
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic run_save(input string tag);
        int n;
        @(negedge clk) save_start = 1'b1;
        @(negedge clk) save_start = 1'b0;
        n = 0;
        while (save_busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_finished"}, {31'd0, save_busy}, 32'd0);
    endtask

    task automatic check_hdr(input string tag, input int first, input logic [27:0] base,
                             input logic [7:0] e [16]);
        check({tag, "_present"}, {31'd0, (wa_q.size() >= first + 16)}, 32'd1);
        if (wa_q.size() >= first + 16) begin
            for (int b = 0; b < 16; b++) begin
                check($sformatf("%s_addr%0d", tag, b), {4'd0, wa_q[first + b]}, {4'd0, base + 28'(b)});
                check($sformatf("%s_data%0d", tag, b), {24'd0, wd_q[first + b]}, {24'd0, e[b]});
            end
        end
    endtask

    logic [7:0] hdr_a [16] = '{8'h4D, 8'h53, 8'h58, 8'h01, 8'h01, 8'h02, 8'h03, 8'h05,
                               8'h02, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] hdr_b [16] = '{8'h4D, 8'h53, 8'h58, 8'h01, 8'h03, 8'h00, 8'h01, 8'h02,
                               8'h0F, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    task automatic load_entry0();
        cfg[0] = '{slot: 2'd1, sub_slot: 2'd2, start_block: 2'd3, typ: MSX::CONFIG_RAM,
                   block_id: 4'd2, block_count: 8'd8, store_address: 28'h10};
    endtask

    initial begin
        int n;
        logic found;
        clear_cfg();

        // Reset state
        #12;
        check("rst_wr", {31'd0, ddr3_wr}, 32'd0);
        check("rst_req", {31'd0, ddr3_request}, 32'd0);
        check("rst_busy", {31'd0, save_busy}, 32'd0);
        check("rst_done", {31'd0, save_done}, 32'd0);
        check("rst_addr", {4'd0, ddr3_addr}, 32'd0);
        check("rst_din", {24'd0, ddr3_din}, 32'd0);
        check("rst_cnt", {22'd0, written_count, skipped_bad}, 32'd0);
        @(negedge clk) reset_n = 1'b1;

        // Single entry 0
        load_entry0();
        clear_log();
        run_save("t1");
        check("t1_nwr", wa_q.size(), 32'd16);
        check_hdr("t1", 0, 28'h0, hdr_a);
        check("t1_written", {27'd0, written_count}, 32'd1);
        check("t1_skipped", {27'd0, skipped_bad}, 32'd0);
        check("t1_done", {31'd0, save_done}, 32'd1);
        check("t1_req_low", {31'd0, ddr3_request}, 32'd0);
        @(negedge clk) save_ack = 1'b1;
        @(negedge clk) save_ack = 1'b0;
        check("t1_ack_clears", {31'd0, save_done}, 32'd0);

        // All entries NONE
        clear_cfg();
        clear_log();
        @(negedge clk) save_start = 1'b1;
        @(negedge clk) save_start = 1'b0;
        check("t2_req_high", {31'd0, ddr3_request}, 32'd1);
        n = 0;
        while (save_busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("t2_finished", {31'd0, save_busy}, 32'd0);
        check("t2_nwr", wa_q.size(), 32'd0);
        check("t2_done", {31'd0, save_done}, 32'd1);
        check("t2_written", {27'd0, written_count}, 32'd0);
        check("t2_req_low", {31'd0, ddr3_request}, 32'd0);
        @(negedge clk) save_ack = 1'b1;
        @(negedge clk) save_ack = 1'b0;

        // Entries 0 and 5 valid, entry 3 has a bad address
        clear_cfg();
        load_entry0();
        cfg[3] = '{slot: 2'd0, sub_slot: 2'd0, start_block: 2'd0, typ: MSX::CONFIG_RAM,
                   block_id: 4'd1, block_count: 8'd1, store_address: 28'h8};
        cfg[5] = '{slot: 2'd3, sub_slot: 2'd0, start_block: 2'd1, typ: MSX::CONFIG_ROM,
                   block_id: 4'hF, block_count: 8'h20, store_address: 28'h80010};
        clear_log();
        run_save("t3");
        check("t3_nwr", wa_q.size(), 32'd32);
        check_hdr("t3a", 0, 28'h0, hdr_a);
        check_hdr("t3b", 16, 28'h80000, hdr_b);
        check("t3_written", {27'd0, written_count}, 32'd2);
        check("t3_skipped", {27'd0, skipped_bad}, 32'd1);
        @(negedge clk) save_ack = 1'b1;
        @(negedge clk) save_ack = 1'b0;

        // Stall at byte 7 for 20 cycles
        clear_cfg();
        load_entry0();
        clear_log();
        @(negedge clk) save_start = 1'b1;
        @(negedge clk) save_start = 1'b0;
        found = 1'b0;
        n = 0;
        while (!found && n < 500) begin
            if (ddr3_wr && ddr3_addr == 28'h7) found = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        check("t4_reach_b7", {31'd0, found}, 32'd1);
        ddr3_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check($sformatf("t4_stall_wr%0d", c), {31'd0, ddr3_wr}, 32'd1);
            check($sformatf("t4_stall_addr%0d", c), {4'd0, ddr3_addr}, 32'h7);
            check($sformatf("t4_stall_din%0d", c), {24'd0, ddr3_din}, 32'h05);
        end
        ddr3_ready = 1'b1;
        n = 0;
        while (save_busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("t4_finished", {31'd0, save_busy}, 32'd0);
        check("t4_nwr", wa_q.size(), 32'd16);
        check_hdr("t4", 0, 28'h0, hdr_a);
        @(negedge clk) save_ack = 1'b1;
        @(negedge clk) save_ack = 1'b0;

        // Second start while busy is ignored; ack held across the set cycle
        clear_log();
        @(negedge clk) save_start = 1'b1;
        @(negedge clk) save_start = 1'b0;
        repeat (5) @(negedge clk);
        save_start = 1'b1;
        save_ack = 1'b1;
        @(negedge clk) save_start = 1'b0;
        n = 0;
        while (save_busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("t5_finished", {31'd0, save_busy}, 32'd0);
        check("t5_set_wins", {31'd0, save_done}, 32'd1);
        @(negedge clk);
        check("t5_ack_clears", {31'd0, save_done}, 32'd0);
        save_ack = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_no_restart", {31'd0, save_busy}, 32'd0);
        check("t5_nwr", wa_q.size(), 32'd16);
        check("t5_written", {27'd0, written_count}, 32'd1);

        // Reset at byte 9, then a fresh save from byte 0
        clear_log();
        @(negedge clk) save_start = 1'b1;
        @(negedge clk) save_start = 1'b0;
        found = 1'b0;
        n = 0;
        while (!found && n < 500) begin
            if (ddr3_wr && ddr3_addr == 28'h9) found = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        check("t6_reach_b9", {31'd0, found}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("t6_wr_drop", {31'd0, ddr3_wr}, 32'd0);
        check("t6_busy_drop", {31'd0, save_busy}, 32'd0);
        check("t6_req_drop", {31'd0, ddr3_request}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        clear_log();
        repeat (3) @(negedge clk);
        check("t6_idle", {31'd0, save_busy}, 32'd0);
        check("t6_no_writes", wa_q.size(), 32'd0);
        check("t6_cnt_clr", {27'd0, written_count}, 32'd0);
        run_save("t6");
        check("t6_nwr", wa_q.size(), 32'd16);
        check_hdr("t6", 0, 28'h0, hdr_a);
        check("t6_written", {27'd0, written_count}, 32'd1);

        check("req_tracks_busy", req_err, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
